// File: rtl/v_issue_ctrl_if.sv
// rtl/v_issue_ctrl_if.sv - instruction handshake between the base processor and the vector issue controller
interface v_issue_ctrl_if;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        instr_ready;

  modport master (output instr_valid, output instr_in, input  instr_ready);
  modport slave  (input  instr_valid, input  instr_in, output instr_ready);
endinterface

// File: rtl/v_issue_ctrl.sv
// rtl/v_issue_ctrl.sv - single-issue sequencer: accept, start unit, wait done/timeout, writeback
module v_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             nrst,
  v_issue_ctrl_if.slave    instr_bus,
  input  logic [2:0]       unit_sel,
  input  logic             dec_vreg_wr,
  input  logic             dec_xreg_wr,
  input  logic [6:0]       unit_done,
  output logic [31:0]      instr_hold,
  output logic [6:0]       unit_start,
  output logic             vconfig_wr_en,
  output logic             v_reg_wr_en,
  output logic             x_reg_wr_en,
  output logic             busy,
  output logic             illegal_err,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam logic [2:0]       SEL_ILLEGAL = 3'd0;
  localparam logic [2:0]       SEL_VSTORE  = 3'd6;
  localparam logic [2:0]       SEL_VCONFIG = 3'd7;
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [31:0]      r_instr_hold;
  logic [6:0]       r_unit_start;
  logic             r_vconfig_wr_en;
  logic             r_v_reg_wr_en;
  logic             r_x_reg_wr_en;
  logic             r_illegal_err;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [2:0]       r_sel;
  logic             r_vreg_wr;
  logic             r_xreg_wr;

  logic [2:0]       w_go_sel;
  logic             w_go_vreg;
  logic             w_go_xreg;
  logic [7:0]       w_done_ext;
  logic [7:0]       w_onehot;
  logic             w_sel_done;

  // In ISSUE the decoder is live; afterwards the latched copy steers done/writeback.
  assign w_go_sel   = (r_state == S_ISSUE) ? unit_sel    : r_sel;
  assign w_go_vreg  = (r_state == S_ISSUE) ? dec_vreg_wr : r_vreg_wr;
  assign w_go_xreg  = (r_state == S_ISSUE) ? dec_xreg_wr : r_xreg_wr;
  assign w_done_ext = {unit_done, 1'b0};
  assign w_onehot   = 8'd1 << unit_sel;
  assign w_sel_done = w_done_ext[w_go_sel];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state         <= S_IDLE;
      r_instr_hold    <= '0;
      r_unit_start    <= '0;
      r_vconfig_wr_en <= 1'b0;
      r_v_reg_wr_en   <= 1'b0;
      r_x_reg_wr_en   <= 1'b0;
      r_illegal_err   <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_retire_cnt    <= '0;
      r_tmo_cnt       <= '0;
      r_sel           <= '0;
      r_vreg_wr       <= 1'b0;
      r_xreg_wr       <= 1'b0;
    end else begin
      r_unit_start    <= '0;
      r_vconfig_wr_en <= 1'b0;
      r_v_reg_wr_en   <= 1'b0;
      r_x_reg_wr_en   <= 1'b0;
      // Clear first so any error set later in this cycle takes precedence.
      if (err_clr) begin
        r_illegal_err <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (instr_bus.instr_valid) begin
            r_instr_hold <= instr_bus.instr_in;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_sel     <= unit_sel;
          r_vreg_wr <= dec_vreg_wr;
          r_xreg_wr <= dec_xreg_wr;
          if (unit_sel == SEL_ILLEGAL) begin
            r_illegal_err <= 1'b1;
            r_state       <= S_IDLE;
          end else if (unit_sel == SEL_VCONFIG) begin
            r_vconfig_wr_en <= 1'b1;
            r_retire_cnt    <= r_retire_cnt + 1'b1;
            r_state         <= S_IDLE;
          end else begin
            r_unit_start <= w_onehot[7:1];
            r_tmo_cnt    <= '0;
            if (w_sel_done) begin
              r_v_reg_wr_en <= w_go_vreg && (w_go_sel != SEL_VSTORE);
              r_x_reg_wr_en <= w_go_xreg && (w_go_sel != SEL_VSTORE);
              r_retire_cnt  <= r_retire_cnt + 1'b1;
              r_state       <= S_WB;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Done is checked before the timeout so a coincident done still retires.
          if (w_sel_done) begin
            r_v_reg_wr_en <= w_go_vreg && (w_go_sel != SEL_VSTORE);
            r_x_reg_wr_en <= w_go_xreg && (w_go_sel != SEL_VSTORE);
            r_retire_cnt  <= r_retire_cnt + 1'b1;
            r_state       <= S_WB;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_bus.instr_ready = (r_state == S_IDLE);
  assign busy                  = (r_state != S_IDLE);
  assign instr_hold            = r_instr_hold;
  assign unit_start            = r_unit_start;
  assign vconfig_wr_en         = r_vconfig_wr_en;
  assign v_reg_wr_en           = r_v_reg_wr_en;
  assign x_reg_wr_en           = r_x_reg_wr_en;
  assign illegal_err           = r_illegal_err;
  assign timeout_err           = r_timeout_err;
  assign retire_cnt            = r_retire_cnt;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// tb/tb_v_issue_ctrl.sv - directed bench for v_issue_ctrl (TIMEOUT_CYCLES=8, CNT_W=4)
module tb_v_issue_ctrl;
  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  unit_sel;
  logic        dec_vreg_wr;
  logic        dec_xreg_wr;
  logic [6:0]  unit_done;
  logic [31:0] instr_hold;
  logic [6:0]  unit_start;
  logic        vconfig_wr_en;
  logic        v_reg_wr_en;
  logic        x_reg_wr_en;
  logic        busy;
  logic        illegal_err;
  logic        timeout_err;
  logic        err_clr;
  logic [3:0]  retire_cnt;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;

  v_issue_ctrl_if u_if ();

  v_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut (
    .clk(clk), .nrst(nrst), .instr_bus(u_if.slave),
    .unit_sel(unit_sel), .dec_vreg_wr(dec_vreg_wr), .dec_xreg_wr(dec_xreg_wr),
    .unit_done(unit_done), .instr_hold(instr_hold), .unit_start(unit_start),
    .vconfig_wr_en(vconfig_wr_en), .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en),
    .busy(busy), .illegal_err(illegal_err), .timeout_err(timeout_err),
    .err_clr(err_clr), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; u_if.instr_valid = 1'b0; u_if.instr_in = '0;
    unit_sel = 3'd0; dec_vreg_wr = 1'b0; dec_xreg_wr = 1'b0; unit_done = '0; err_clr = 1'b0;
    step(); step();
    chk("rst_ready", u_if.instr_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_hold", instr_hold, 0); chk("rst_start", unit_start, 0);
    chk("rst_retire", retire_cnt, 0); chk("rst_errs", {illegal_err, timeout_err}, 0);
    chk("rst_wr", {vconfig_wr_en, v_reg_wr_en, x_reg_wr_en}, 0);
    nrst = 1'b1;

    // Reset in WAIT, then a stale done
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h1111_1111; unit_sel = 3'd1; dec_vreg_wr = 1'b1;
    step();
    chk("rw_busy_issue", busy, 1); chk("rw_ready_issue", u_if.instr_ready, 0);
    chk("rw_hold", instr_hold, 32'h1111_1111);
    u_if.instr_valid = 1'b0;
    step();
    chk("rw_start", unit_start, 7'b0000001);
    step();
    nrst = 1'b0; #1;
    chk("rw_async_busy", busy, 0); chk("rw_async_ready", u_if.instr_ready, 1);
    chk("rw_async_hold", instr_hold, 0);
    nrst = 1'b1; unit_done = 7'b0000001;
    step();
    chk("rw_stale_vwr", v_reg_wr_en, 0);
    unit_done = '0;
    step();
    chk("rw_stale_busy", busy, 0); chk("rw_stale_retire", retire_cnt, 0);

    // valu add, done 3 cycles after start
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h0220_80D7; unit_sel = 3'd1; dec_vreg_wr = 1'b1; dec_xreg_wr = 1'b0;
    step();
    u_if.instr_valid = 1'b0; u_if.instr_in = 32'hDEAD_BEEF;
    chk("add_start_issue", unit_start, 0); chk("add_hold_issue", instr_hold, 32'h0220_80D7);
    step();
    chk("add_start", unit_start, 7'b0000001);
    step();
    chk("add_start_gone", unit_start, 0); chk("add_hold_wait", instr_hold, 32'h0220_80D7);
    step();
    unit_done = 7'b0000001;
    step();
    unit_done = '0;
    chk("add_vwr", v_reg_wr_en, 1); chk("add_xwr", x_reg_wr_en, 0);
    chk("add_retire", retire_cnt, 1); chk("add_busy_wb", busy, 1);
    chk("add_hold_wb", instr_hold, 32'h0220_80D7);
    step();
    chk("add_vwr_one", v_reg_wr_en, 0); chk("add_ready", u_if.instr_ready, 1);

    // vconfig then vred with done coincident with issue
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h0081_7057; unit_sel = 3'd7;
    step();
    chk("cfg_ready_issue", u_if.instr_ready, 0);
    u_if.instr_in = 32'h0620_A057;
    step();
    chk("cfg_wr", vconfig_wr_en, 1); chk("cfg_retire", retire_cnt, 2);
    chk("cfg_ready", u_if.instr_ready, 1);
    unit_sel = 3'd3; dec_vreg_wr = 1'b1; unit_done = 7'b0000100;
    step();
    u_if.instr_valid = 1'b0;
    chk("cfg_wr_one", vconfig_wr_en, 0); chk("red_hold", instr_hold, 32'h0620_A057);
    step();
    chk("red_start", unit_start, 7'b0000100); chk("red_vwr", v_reg_wr_en, 1);
    chk("red_retire", retire_cnt, 3); chk("red_busy_wb", busy, 1);
    unit_done = '0;
    step();
    chk("red_ready", u_if.instr_ready, 1); chk("red_vwr_one", v_reg_wr_en, 0);

    // vload timeout after 8 WAIT cycles
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h0200_0007; unit_sel = 3'd5; dec_vreg_wr = 1'b1;
    step();
    u_if.instr_valid = 1'b0;
    step();
    chk("tmo_start", unit_start, 7'b0010000);
    for (int i = 0; i < 7; i++) step();
    chk("tmo_busy_c7", busy, 1); chk("tmo_err_early", timeout_err, 0);
    step();
    chk("tmo_err", timeout_err, 1); chk("tmo_idle", busy, 0);
    chk("tmo_wr", {v_reg_wr_en, x_reg_wr_en}, 0); chk("tmo_retire", retire_cnt, 3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo_clr", timeout_err, 0);

    // vmul: done from valu ignored
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h9620_0057; unit_sel = 3'd2; dec_vreg_wr = 1'b1; dec_xreg_wr = 1'b1;
    step();
    u_if.instr_valid = 1'b0;
    step();
    chk("mul_start", unit_start, 7'b0000010);
    unit_done = 7'b0000001;
    step();
    chk("mul_wrong_busy", busy, 1); chk("mul_wrong_vwr", v_reg_wr_en, 0);
    unit_done = 7'b0000010;
    step();
    unit_done = '0;
    chk("mul_vwr", v_reg_wr_en, 1); chk("mul_xwr", x_reg_wr_en, 1); chk("mul_retire", retire_cnt, 4);
    step();
    chk("mul_xwr_one", x_reg_wr_en, 0);

    // done coincident with the timeout cycle
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h0200_0007; unit_sel = 3'd5; dec_vreg_wr = 1'b1; dec_xreg_wr = 1'b0;
    step();
    u_if.instr_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    unit_done = 7'b0010000;
    step();
    unit_done = '0;
    chk("race_err", timeout_err, 0); chk("race_vwr", v_reg_wr_en, 1); chk("race_retire", retire_cnt, 5);
    step();

    // vstore suppresses writeback
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h0200_0027; unit_sel = 3'd6; dec_vreg_wr = 1'b1; dec_xreg_wr = 1'b1;
    step();
    u_if.instr_valid = 1'b0;
    step();
    unit_done = 7'b0100000;
    step();
    unit_done = '0;
    chk("st_wr", {v_reg_wr_en, x_reg_wr_en}, 0); chk("st_retire", retire_cnt, 6); chk("st_busy_wb", busy, 1);
    step();

    // illegal instruction, then set-vs-clear
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'hFFFF_FFFF; unit_sel = 3'd0;
    step();
    u_if.instr_valid = 1'b0;
    step();
    chk("ill_err", illegal_err, 1); chk("ill_start", unit_start, 0);
    chk("ill_retire", retire_cnt, 6); chk("ill_idle", busy, 0);
    u_if.instr_valid = 1'b1;
    step();
    u_if.instr_valid = 1'b0; err_clr = 1'b1;
    step();
    chk("ill_set_wins", illegal_err, 1);
    step();
    err_clr = 1'b0;
    chk("ill_clr", illegal_err, 0);

    // retire_cnt wrap (CNT_W=4): 6 + 9 = 15, one more wraps to 0
    u_if.instr_valid = 1'b1; u_if.instr_in = 32'h0081_7057; unit_sel = 3'd7;
    for (int i = 0; i < 9; i++) begin step(); step(); end
    chk("wrap_15", retire_cnt, 15);
    step(); step();
    u_if.instr_valid = 1'b0;
    chk("wrap_0", retire_cnt, 0);
    step();
    chk("end_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/v_issue_ctrl.md
Name: v_issue_ctrl

Overview:
- Single-issue sequencer between the base processor and the vector coprocessor datapath (vector ALU/MUL lanes, reduction unit, slide unit, load unit, store path, CSR).
- Accepts one vector instruction at a time over a valid/ready handshake and holds it stable for the decoder.
- Pulses the selected unit's start, waits for that unit's done (with timeout), then issues a one-cycle register writeback enable; CSR config instructions are retired directly.
- Provides busy/stall status, sticky error flags and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT before abort; legal range 2..65535.
- CNT_W, 16, width of the timeout counter and of retire_cnt.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- instr_valid  in  1  base processor presents an instruction.
- instr_in  in  32  instruction word.
- instr_ready  out  1  controller can accept; high only in IDLE.
- unit_sel  in  3  decoder unit class for instr_hold: 0 illegal, 1 valu, 2 vmul, 3 vred, 4 vsldu, 5 vload, 6 vstore, 7 vconfig.
- dec_vreg_wr  in  1  decoder: instruction writes a vector register.
- dec_xreg_wr  in  1  decoder: instruction writes a scalar register.
- unit_done  in  7  per-unit done, bit i-1 = unit_sel i (units 1..7).
- instr_hold  out  32  latched instruction driven to the decoder/CSR.
- unit_start  out  7  one-hot, one-cycle start pulse to the selected unit.
- vconfig_wr_en  out  1  one-cycle CSR write strobe.
- v_reg_wr_en  out  1  one-cycle vector regfile write enable.
- x_reg_wr_en  out  1  one-cycle scalar writeback enable.
- busy  out  1  high whenever state != IDLE.
- illegal_err  out  1  sticky, illegal instruction seen.
- timeout_err  out  1  sticky, unit timed out.
- err_clr  in  1  synchronous clear of both sticky errors.
- retire_cnt  out  CNT_W  count of instructions that reached WB or config retire; wraps.

Behaviour:
- Reset (async, nrst low): state IDLE; instr_hold=0; unit_start=0; all wr enables 0; busy=0; both errors 0; retire_cnt=0; timeout counter 0. Reset during ISSUE/WAIT/WB aborts the instruction with no writeback. Any unit_done arriving after reset is ignored.
- The decoder sees instr_hold combinationally; unit_sel, dec_vreg_wr and dec_xreg_wr are sampled in ISSUE and latched.
- IDLE: instr_ready=1. When instr_valid=1, latch instr_in into instr_hold and go to ISSUE. instr_hold is unchanged while not in IDLE.
- ISSUE (1 cycle): latch the decoder flags.
  - unit_sel=0: set illegal_err, go to IDLE; no start pulse, no retire.
  - unit_sel=7: vconfig_wr_en=1 this cycle, retire_cnt+1, go to IDLE.
  - Otherwise: unit_start[unit_sel-1]=1, clear the timeout counter, go to WAIT. If the selected done bit is already high this cycle, go directly to WB.
- WAIT:
  - Selected unit_done bit high: go to WB.
  - Done bits of non-selected units: ignored.
  - Counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no done: set timeout_err, go to IDLE, no writeback, no retire.
  - A done that arrives in the same cycle as the timeout wins: go to WB, no error.
- WB (1 cycle): v_reg_wr_en=latched dec_vreg_wr and x_reg_wr_en=latched dec_xreg_wr, both forced 0 for unit_sel=6 (vstore). retire_cnt+1. Go to IDLE.
- Latency: accept at edge 0, ISSUE cycle 1, earliest WB cycle 1 or 2, instr_ready high again the following cycle. Best-case throughput is one instruction per 3 cycles; a config instruction takes 2 cycles.
- Error flags:
  - err_clr clears both flags on the next edge.
  - If set and clear coincide in the same cycle, set wins.
  - Errors do not block issue.
- retire_cnt wraps from 2^CNT_W-1 to 0.
- All outputs are registered except instr_ready and busy, which decode the state register.

Test Plan:
- Reset mid-WAIT: issue valu (unit_sel=1), assert nrst=0 in WAIT, then pulse unit_done[0] after release -> no v_reg_wr_en, state IDLE, instr_ready=1, retire_cnt=0.
- valu add: instr_in=0x0220_80D7, unit_sel=1, dec_vreg_wr=1, done 3 cycles after start -> unit_start=0000001 for one cycle, v_reg_wr_en for exactly one cycle, retire_cnt=1, instr_hold stable throughout.
- Back-to-back: vconfig (unit_sel=7) then vred (unit_sel=3) with done same cycle as start -> vconfig_wr_en pulse, then WB one cycle after ISSUE, retire_cnt=2, instr_ready low only while busy.
- Timeout: TIMEOUT_CYCLES=8, vload, no done -> timeout_err=1 after 8 WAIT cycles, no write enables, retire_cnt unchanged; err_clr -> timeout_err=0.
- Wrong unit done: vmul selected, pulse unit_done[0] (valu) then unit_done[1] -> only the second ends WAIT.
- vstore with dec_vreg_wr=1 -> no v_reg_wr_en; unit_sel=0 -> illegal_err=1, no start; retire_cnt wrap check with CNT_W=4 after 16 retires -> 0.
